wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Writeback trace buffer that sits directly downstream of the CPU core's debug writeback port (debug_wb_pc / rf_wen / rf_wnum / rf_wdata). It captures every architecturally visible register write into a small FIFO and presents the records on a valid/ready stream to the trace comparator or UART dumper. Dropped records on overflow are counted and flagged, so the consumer can detect gaps.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- PTR_W, 4, log2(DEPTH); must match DEPTH
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- debug_wb_pc  in  32  writeback PC from the core
- debug_wb_rf_wen  in  4  byte write enables from the core
- debug_wb_rf_wnum  in  5  destination register number
- debug_wb_rf_wdata  in  32  write data
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts head record
- trace_pc  out  32  head record PC
- trace_wnum  out  5  head record register number
- trace_wdata  out  32  head record data
- trace_gap  out  1  at least one record dropped immediately before this one
- trace_seq  out  16  capture sequence number of head record
- trace_count  out  PTR_W+1  current occupancy, 0..DEPTH
- drop_cnt  out  16  total dropped records, saturating
- overflow  out  1  sticky: any drop since reset

## Operation
- Capture event: debug_wb_rf_wen != 4'b0000 and debug_wb_rf_wnum != 0. Writes to $0 are ignored entirely (no push, no seq increment, no drop).
- Record = {pc, wnum, wdata, gap, seq}; stored in a register array indexed by wr_ptr/rd_ptr (PTR_W bits, natural wrap at DEPTH).
- Pop: trace_valid && trace_ready. Head outputs driven combinationally from mem[rd_ptr]; trace_valid = (count != 0).
- Push accepted when capture && (count < DEPTH || pop). Full with simultaneous pop: both happen, count stays DEPTH.
- Drop: capture && count == DEPTH && !pop. drop_cnt += 1 (saturates at 16'hFFFF), overflow set, internal gap_pend set.
- gap bit of a pushed record = gap_pend; gap_pend clears on that push. Drops and push in the same cycle cannot occur.
- Empty with capture and trace_ready high: no bypass; record pushed, trace_valid rises next cycle.
- Head outputs are don't-care when trace_valid is low; the bench must not check them.

## Timing
- Reset (resetn low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, trace_valid = 0, trace_gap = 0, trace_seq = 0 (head data read from cleared array: trace_pc = 0, trace_wnum = 0, trace_wdata = 0), drop_cnt = 0, overflow = 0, gap_pend = 0, seq counter = 0. Array contents cleared to zero.
- Reset mid-stream discards all buffered records; no partial record survives.
- Latency: capture sampled at edge N → trace_valid high and record at head after edge N; visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained; count updates by +1, -1 or 0 per edge.
- trace_ready may toggle freely; head record and trace_valid stay stable while trace_valid && !trace_ready.
- drop_cnt and overflow update on the edge of the dropped capture.

## Configuration
- WB_TRACE_SEQ_EN defined: 16-bit sequence counter increments on every capture event (pushed or dropped), wrapping 16'hFFFF → 0; value before increment is stored with a pushed record and appears on trace_seq.
- Not defined: no sequence counter or seq storage; trace_seq tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset then single write pc=0xBFC00000, wen=4'hF, wnum=5, wdata=0x1234 with trace_ready=1 → trace_valid one cycle later, trace_pc=0xBFC00000, trace_wnum=5, trace_wdata=0x1234, trace_gap=0, trace_seq=0; count returns to 0 after pop.
- Write with wnum=0 or wen=0 → no push, count stays 0, seq unchanged (next real record shows seq=0).
- trace_ready=0, 18 consecutive captures with DEPTH=16 → count=16, drop_cnt=2, overflow=1; draining yields 16 records with seq 0..15, none with gap; next capture pushed with trace_gap=1, seq=18.
- Full FIFO, trace_ready=1 and capture same cycle → pop and push both occur, count stays 16, drop_cnt unchanged.
- Stall trace_ready=0 for 5 cycles with valid high → head outputs unchanged all 5 cycles; release → records drain in capture order.
- Assert resetn=0 mid-cycle with 7 records buffered → trace_valid and count drop to 0 immediately; drop_cnt=0, overflow=0; build without WB_TRACE_SEQ_EN → trace_seq=0 for every record.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Writeback trace buffer: captures core register writes into a FIFO and streams them out.
// Optional macro WB_TRACE_SEQ_EN adds a 16-bit capture sequence number to every record.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      debug_wb_pc,
  input  logic [3:0]       debug_wb_rf_wen,
  input  logic [4:0]       debug_wb_rf_wnum,
  input  logic [31:0]      debug_wb_rf_wdata,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [4:0]       trace_wnum,
  output logic [31:0]      trace_wdata,
  output logic             trace_gap,
  output logic [15:0]      trace_seq,
  output logic [PTR_W:0]   trace_count,
  output logic [15:0]      drop_cnt,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             gap_pend_reg;

  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_wnum  [DEPTH];
  logic [31:0] mem_wdata [DEPTH];
  logic        mem_gap   [DEPTH];

  logic capture;
  logic pop;
  logic push;
  logic drop;

  // Writes to $0 are architecturally invisible, so they never enter the trace.
  assign capture = (debug_wb_rf_wen != 4'b0000) && (debug_wb_rf_wnum != 5'd0);
  assign trace_valid = (count_reg != '0);
  assign pop  = trace_valid && trace_ready;
  assign push = capture && ((count_reg != FULL_CNT) || pop);
  assign drop = capture && (count_reg == FULL_CNT) && !pop;

  assign trace_count = count_reg;
  assign trace_pc    = mem_pc[rd_ptr_reg];
  assign trace_wnum  = mem_wnum[rd_ptr_reg];
  assign trace_wdata = mem_wdata[rd_ptr_reg];
  assign trace_gap   = mem_gap[rd_ptr_reg];

`ifdef WB_TRACE_SEQ_EN
  logic [15:0] seq_reg;
  logic [15:0] mem_seq [DEPTH];

  // Dropped captures still consume a sequence number so gaps are measurable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_reg <= '0;
    end else if (capture) begin
      seq_reg <= seq_reg + 16'd1;
    end
  end

  assign trace_seq = mem_seq[rd_ptr_reg];
`else
  assign trace_seq = 16'h0000;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_wnum[i]  <= '0;
        mem_wdata[i] <= '0;
        mem_gap[i]   <= 1'b0;
`ifdef WB_TRACE_SEQ_EN
        mem_seq[i]   <= '0;
`endif
      end
    end else if (push) begin
      mem_pc[wr_ptr_reg]    <= debug_wb_pc;
      mem_wnum[wr_ptr_reg]  <= debug_wb_rf_wnum;
      mem_wdata[wr_ptr_reg] <= debug_wb_rf_wdata;
      mem_gap[wr_ptr_reg]   <= gap_pend_reg;
`ifdef WB_TRACE_SEQ_EN
      mem_seq[wr_ptr_reg]   <= seq_reg;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      gap_pend_reg <= 1'b0;
      drop_cnt     <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow     <= 1'b1;
        gap_pend_reg <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (push) begin
        gap_pend_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed table, corner sequences, random vs. queue model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
`ifdef WB_TRACE_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc = '0;
  logic [3:0]  wen = '0;
  logic [4:0]  wnum = '0;
  logic [31:0] wdata = '0;
  logic        ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic        trace_gap;
  logic [15:0] trace_seq;
  logic [PTR_W:0] trace_count;
  logic [15:0] drop_cnt;
  logic        overflow;

  wb_trace_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn),
    .debug_wb_pc(pc), .debug_wb_rf_wen(wen), .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
    .trace_valid(trace_valid), .trace_ready(ready),
    .trace_pc(trace_pc), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
    .trace_gap(trace_gap), .trace_seq(trace_seq), .trace_count(trace_count),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        gap;
    logic [15:0] seq;
  } rec_t;

  rec_t        q[$];
  int          m_drop;
  bit          m_ovf;
  bit          m_gap_pend;
  logic [15:0] m_seq;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ovf = 1'b0;
    m_gap_pend = 1'b0;
    m_seq = '0;
  endtask

  // One clock edge of the FIFO rules, applied to the current inputs.
  task automatic model_step();
    bit   cap;
    bit   do_pop;
    int   n;
    rec_t r;
    cap = (wen != 4'b0000) && (wnum != 5'd0);
    n = q.size();
    do_pop = (n != 0) && ready;
    if (do_pop) r = q.pop_front();
    if (cap) begin
      if (n < DEPTH || do_pop) begin
        r.pc = pc;
        r.wnum = wnum;
        r.wdata = wdata;
        r.gap = m_gap_pend;
        r.seq = SEQ_EN ? m_seq : 16'h0000;
        q.push_back(r);
        m_gap_pend = 1'b0;
      end else begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
        m_gap_pend = 1'b1;
      end
      m_seq = m_seq + 16'd1;
    end
  endtask

  task automatic check_model();
    chk("valid", {31'b0, trace_valid}, {31'b0, q.size() != 0});
    chk("count", {27'b0, trace_count}, q.size());
    chk("drop_cnt", {16'b0, drop_cnt}, m_drop);
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (q.size() != 0) begin
      chk("head_pc", trace_pc, q[0].pc);
      chk("head_wnum", {27'b0, trace_wnum}, {27'b0, q[0].wnum});
      chk("head_wdata", trace_wdata, q[0].wdata);
      chk("head_gap", {31'b0, trace_gap}, {31'b0, q[0].gap});
      chk("head_seq", {16'b0, trace_seq}, {16'b0, q[0].seq});
    end
  endtask

  // Called at a falling edge: model the coming rising edge, then check at the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic set_in(input logic [31:0] p, input logic [3:0] e, input logic [4:0] n,
                        input logic [31:0] d, input logic r);
    pc = p; wen = e; wnum = n; wdata = d; ready = r;
  endtask

  task automatic do_reset();
    set_in(32'h0, 4'h0, 5'd0, 32'h0, 1'b0);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, trace_valid}, 32'd0);
    chk("rst_count", {27'b0, trace_count}, 32'd0);
    chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_pc", trace_pc, 32'd0);
    chk("rst_seq", {16'b0, trace_seq}, 32'd0);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        rst_before;
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_count;
    logic [31:0] exp_pc;
    logic [4:0]  exp_wnum;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] s_pc, s_wdata;
    logic [4:0]  s_wnum;
    logic [15:0] s_seq;
    int          bias;

    tbl[0] = '{1'b1, 32'hBFC00000, 4'hF, 5'd5, 32'h1234, 1'b1, 1'b1, 5'd1, 32'hBFC00000, 5'd5, 32'h1234};
    tbl[1] = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0};
    tbl[2] = '{1'b1, 32'h200, 4'hF, 5'd0, 32'hDEAD, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0};
    tbl[3] = '{1'b0, 32'h204, 4'h0, 5'd7, 32'hBEEF, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0};
    tbl[4] = '{1'b0, 32'h208, 4'h3, 5'd3, 32'hAA, 1'b0, 1'b1, 5'd1, 32'h208, 5'd3, 32'hAA};
    tbl[5] = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst_before) do_reset();
      set_in(tbl[i].pc, tbl[i].wen, tbl[i].wnum, tbl[i].wdata, tbl[i].ready);
      cycle();
      chk("tbl_valid", {31'b0, trace_valid}, {31'b0, tbl[i].exp_valid});
      chk("tbl_count", {27'b0, trace_count}, {27'b0, tbl[i].exp_count});
      if (tbl[i].exp_valid) begin
        chk("tbl_pc", trace_pc, tbl[i].exp_pc);
        chk("tbl_wnum", {27'b0, trace_wnum}, {27'b0, tbl[i].exp_wnum});
        chk("tbl_wdata", trace_wdata, tbl[i].exp_wdata);
        chk("tbl_gap", {31'b0, trace_gap}, 32'd0);
        chk("tbl_seq", {16'b0, trace_seq}, 32'd0);
      end
      $display("vec %0d pc=%h wen=%h wnum=%0d ready=%0d -> valid=%0d count=%0d",
               i, tbl[i].pc, tbl[i].wen, tbl[i].wnum, tbl[i].ready, trace_valid, trace_count);
    end

    // Overflow: 18 captures into a stalled 16-entry FIFO.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_in(32'h1000 + 32'(4 * i), 4'hF, 5'((i % 31) + 1), $urandom, 1'b0);
      cycle();
    end
    chk("ovf_count", {27'b0, trace_count}, 32'd16);
    chk("ovf_drop", {16'b0, drop_cnt}, 32'd2);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    $display("overflow: count=%0d drop_cnt=%0d overflow=%0d", trace_count, drop_cnt, overflow);
    set_in(32'h0, 4'h0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_pc", trace_pc, 32'h1000 + 32'(4 * i));
      chk("drain_gap", {31'b0, trace_gap}, 32'd0);
      chk("drain_seq", {16'b0, trace_seq}, SEQ_EN ? 32'(i) : 32'd0);
      $display("drain %0d pc=%h seq=%0d gap=%0d", i, trace_pc, trace_seq, trace_gap);
      cycle();
    end
    chk("drained_count", {27'b0, trace_count}, 32'd0);
    set_in(32'h2000, 4'h1, 5'd9, 32'h55, 1'b0);
    cycle();
    chk("gap_rec_gap", {31'b0, trace_gap}, 32'd1);
    chk("gap_rec_seq", {16'b0, trace_seq}, SEQ_EN ? 32'd18 : 32'd0);
    $display("gap record pc=%h gap=%0d seq=%0d", trace_pc, trace_gap, trace_seq);

    // Full FIFO with simultaneous pop and capture.
    for (int i = 0; i < 15; i++) begin
      set_in(32'h3000 + 32'(4 * i), 4'hC, 5'd17, $urandom, 1'b0);
      cycle();
    end
    chk("full_count", {27'b0, trace_count}, 32'd16);
    set_in(32'h4000, 4'hF, 5'd2, 32'h77, 1'b1);
    cycle();
    chk("fullpop_count", {27'b0, trace_count}, 32'd16);
    chk("fullpop_drop", {16'b0, drop_cnt}, 32'd2);
    $display("full push+pop: count=%0d drop_cnt=%0d", trace_count, drop_cnt);

    // Stall with valid high: head must hold.
    set_in(32'h0, 4'h0, 5'd0, 32'h0, 1'b0);
    s_pc = trace_pc; s_wnum = trace_wnum; s_wdata = trace_wdata; s_seq = trace_seq;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_valid", {31'b0, trace_valid}, 32'd1);
      chk("stall_pc", trace_pc, s_pc);
      chk("stall_wnum", {27'b0, trace_wnum}, {27'b0, s_wnum});
      chk("stall_wdata", trace_wdata, s_wdata);
      chk("stall_seq", {16'b0, trace_seq}, {16'b0, s_seq});
    end
    set_in(32'h0, 4'h0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 9; i++) cycle();
    chk("pre_rst_count", {27'b0, trace_count}, 32'd7);

    // Asynchronous reset between edges with 7 records buffered.
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", {31'b0, trace_valid}, 32'd0);
    chk("arst_count", {27'b0, trace_count}, 32'd0);
    chk("arst_drop", {16'b0, drop_cnt}, 32'd0);
    chk("arst_ovf", {31'b0, overflow}, 32'd0);
    chk("arst_pc", trace_pc, 32'd0);
    chk("arst_wnum", {27'b0, trace_wnum}, 32'd0);
    chk("arst_wdata", trace_wdata, 32'd0);
    chk("arst_gap", {31'b0, trace_gap}, 32'd0);
    chk("arst_seq", {16'b0, trace_seq}, 32'd0);
    $display("async reset: valid=%0d count=%0d", trace_valid, trace_count);
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic with shifting consumer speed.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = (i / 200 % 3 == 0) ? 10 : ((i / 200 % 3 == 1) ? 90 : 50);
      set_in($urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
             5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 99) < bias);
      cycle();
    end
    $display("random: drop_cnt=%0d overflow=%0d", drop_cnt, overflow);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
